zion_pc_redirect_ctrl: RTL

Redirect scheduler in front of the PC generator. It collects PC-redirect requests from SRC_NUM pipeline sources (exception, branch resolve, predictor, fence, ...) with valid/ready handshakes and buffers one request per source. It drives the one-hot set-enable, set-PC and stall inputs of the PC generator, squashes younger redirects, and sequences a fixed-length front-end flush after every redirect.

---
 rtl/zion_pc_redirect_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/zion_pc_redirect_ctrl.sv
// Redirect scheduler in front of the PC generator: buffers one redirect per source,
// issues the oldest pending one, squashes younger ones and sequences a front-end flush.

module zion_pc_redirect_slot #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  input  logic [PC_WIDTH-1:0] req_pc,
  input  logic                kill,
  output logic                pend,
  output logic [PC_WIDTH-1:0] pc
);
  logic                pend_d, pend_q;
  logic [PC_WIDTH-1:0] pc_d, pc_q;
  logic                cap;

  // A slot that is still pending never captures, so a kill only ever hits the old entry.
  always_comb begin
    cap    = req_vld & ~pend_q;
    pend_d = cap | (pend_q & ~kill);
    pc_d   = cap ? req_pc : pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      pend_q <= pend_d;
      pc_q   <= pc_d;
    end
  end

  assign pend = pend_q;
  assign pc   = pc_q;
endmodule

module zion_pc_redirect_ctrl #(
  parameter int SRC_NUM   = 4,
  parameter int PC_WIDTH  = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SRC_NUM-1:0]                iReqVld,
  input  logic [SRC_NUM-1:0][PC_WIDTH-1:0]  iReqPc,
  output logic [SRC_NUM-1:0]                oReqRdy,
  input  logic                              iFetchRdy,
  output logic [SRC_NUM-1:0]                oPcSetEn,
  output logic [SRC_NUM-1:0][PC_WIDTH-1:0]  oPcSetPc,
  output logic                              oPcStall,
  output logic                              oFlush,
  output logic                              oBusy,
  output logic [CNT_WIDTH-1:0]              oRedirCnt
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC);

  state_t                        state_d, state_q;
  logic [3:0]                    flush_cnt_d, flush_cnt_q;
  logic [CNT_WIDTH-1:0]          redir_cnt_d, redir_cnt_q;
  logic [SRC_NUM-1:0]            pend;
  logic [SRC_NUM-1:0][PC_WIDTH-1:0] pc_buf;
  logic [SRC_NUM-1:0]            sel_oh, ge_sel, kill;
  logic                          found, issue;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_slot
    zion_pc_redirect_slot #(.PC_WIDTH(PC_WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .req_vld (iReqVld[i]),
      .req_pc  (iReqPc[i]),
      .kill    (kill[i]),
      .pend    (pend[i]),
      .pc      (pc_buf[i])
    );
  end

  // ge_sel marks the selected source and every younger one: all are cleared on issue.
  always_comb begin
    found  = 1'b0;
    sel_oh = '0;
    ge_sel = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (pend[i] && !found) sel_oh[i] = 1'b1;
      if (pend[i]) found = 1'b1;
      ge_sel[i] = found;
    end
    issue = (state_q == IDLE) && (pend != '0) && iFetchRdy;
    kill  = issue ? ge_sel : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue && FLUSH_CYC != 0) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_INIT;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    redir_cnt_d = (issue && redir_cnt_q != '1) ? redir_cnt_q + 1'b1 : redir_cnt_q;
  end

  always_comb begin
    oPcSetEn = '0;
    oPcStall = 1'b1;
    oFlush   = 1'b0;
    case (state_q)
      IDLE: begin
        oPcStall = ~iFetchRdy;
        if (issue) oPcSetEn = sel_oh;
      end
      FLUSH: oFlush = 1'b1;
      default: ;
    endcase
  end

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_setpc
    assign oPcSetPc[i] = oPcSetEn[i] ? pc_buf[i] : '0;
  end

  assign oReqRdy   = ~pend;
  assign oBusy     = (pend != '0) || (state_q != IDLE);
  assign oRedirCnt = redir_cnt_q;
endmodule
